sram_256x4096_1rw_ctrl: RTL and testbench
=========================================

Name: sram_256x4096_1rw_ctrl

Overview:
Request/response front-end that sits directly upstream of the sram_256x4096_1rw macro, on the client side. It converts a valid/ready request stream (read or byte-masked write) into the macro's single-cycle ce/we/addr/wd/w_mask strobes. It captures read data one cycle after issue into a small response FIFO, and uses credit accounting so client back-pressure never loses data.

Parameters:
BITS, 256, data width; a multiple of 8
WORD_DEPTH, 4096, number of words
ADDR_WIDTH, 12, address width; equals log2(WORD_DEPTH)
RSP_DEPTH, 2, response FIFO entries; at least 2

Ports:
clk  in  1  single clock; every flop is posedge clk
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&req_ready is high at a clk edge
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  BITS  write data
req_wstrb  in  BITS/8  byte enables; 1 = write the byte
sram_ce  out  1  to macro ce_in
sram_we  out  1  to macro we_in
sram_addr  out  ADDR_WIDTH  to macro addr_in
sram_wd  out  BITS  to macro wd_in
sram_wmask  out  BITS  to macro w_mask_in; 1 = bit written
sram_rd  in  BITS  from macro rd_out; valid the cycle after a read issue
rsp_valid  out  1  read response valid
rsp_ready  in  1  consumer ready
rsp_rdata  out  BITS  read data
idle  out  1  no read in flight and FIFO empty

Behaviour:
- Reset (async assert, sync release): rd_pend=0, FIFO count=0, rd/wr pointers=0, rsp_valid=0, rsp_rdata=0, idle=1. While rst is high, req_ready=0 and sram_ce=0.
- Issue path is combinational: fire = req_valid & req_ready.
  - sram_ce = fire.
  - sram_we = fire & req_we.
  - sram_addr = req_addr.
  - sram_wd = req_wdata.
  - sram_wmask[8i+7:8i] = {8{req_wstrb[i] & req_we}}.
  - The macro samples at the same edge that accepts the request.
- Credit: pop = rsp_valid & rsp_ready; credit_used = count + rd_pend - pop.
- req_ready = !rst & (req_we | credit_used < RSP_DEPTH).
  - req_ready never depends on req_valid.
  - It may depend on req_we and on rsp_ready (same-cycle pop frees a slot).
- Writes are always accepted when not in reset and produce no response.
- Read timing, with a read accepted in cycle c:
  - rd_pend=1 during c+1.
  - sram_rd is pushed into the FIFO at the end of c+1.
  - rsp_valid=1 and rsp_rdata=data in cycle c+2 at the earliest.
- rd_pend next = fire & !req_we.
- FIFO: RSP_DEPTH entries, registered head output (rsp_rdata = head entry).
  - A simultaneous push and pop keeps count unchanged and preserves order.
  - Push when full cannot occur given the credit rule; assert this in simulation.
  - Pointers wrap modulo RSP_DEPTH.
- rsp_rdata holds while rsp_valid & !rsp_ready; data must stay stable until popped.
- Read-after-write to the same address on consecutive cycles returns the new data; the macro handles ordering, and the controller does not reorder.
- Throughput: with rsp_ready held 1, one read per cycle is sustained at RSP_DEPTH=2.
- idle = !rd_pend & (count==0).
- Reset mid-operation: in-flight read and FIFO contents are discarded; no response is produced for them after release.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> req_ready=0, sram_ce=0, rsp_valid=0, idle=1; after release, req_ready=1.
- Write then read: write addr 0x005, data 0xA5 repeated, wstrb all ones -> sram_we=1 and sram_wmask all ones in the accept cycle. Read addr 0x005 -> rsp_valid 2 cycles later with rsp_rdata = 0xA5 pattern.
- Byte mask: write with wstrb=0x0000_0001 (lowest byte only) -> sram_wmask[7:0]=0xFF and every other sram_wmask bit 0.
- Back-pressure: rsp_ready=0 and 4 reads offered back-to-back -> exactly 2 accepted, then req_ready=0 for reads. A write offered meanwhile is still accepted. Raise rsp_ready -> responses return in issue order with no loss or duplication.
- Streaming: rsp_ready=1 and 16 consecutive reads of addrs 0..15 -> req_ready held 1 throughout and 16 in-order responses on consecutive cycles.
- Reset mid-read: assert rst in the cycle after a read issue -> no rsp_valid after release, and idle=1.

Source files
------------

// File: rtl/sram_256x4096_1rw_ctrl.sv
// ============================================================================
//  Module   : sram_256x4096_1rw_ctrl
//  Brief    : Valid/ready request front-end for the sram_256x4096_1rw macro.
//             Credit-gated read issue with a small registered response FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_256x4096_1rw_ctrl #(
    parameter int BITS       = 256,
    parameter int WORD_DEPTH = 4096,
    parameter int ADDR_WIDTH = 12,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    input  logic [BITS/8-1:0]     req_wstrb,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS-1:0]       rsp_rdata,
    output logic                  idle
);

    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int STRB_W = BITS / 8;

    logic                 rd_pend_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [BITS-1:0]      mem_q [RSP_DEPTH];

    logic                 fire;
    logic                 push;
    logic                 pop;
    logic [CNT_W:0]       credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A read reserves a FIFO slot from issue until its data is popped, so the
    // FIFO can never overflow while the consumer stalls.
    assign pop         = rsp_valid & rsp_ready;
    assign credit_used = {1'b0, count_q} + (CNT_W+1)'(rd_pend_q) - (CNT_W+1)'(pop);
    assign req_ready   = !rst && (req_we || (credit_used < (CNT_W+1)'(RSP_DEPTH)));
    assign fire        = req_valid & req_ready;
    assign push        = rd_pend_q;

    assign sram_ce   = fire;
    assign sram_we   = fire & req_we;
    assign sram_addr = req_addr;
    assign sram_wd   = req_wdata;

    for (genvar i = 0; i < STRB_W; i++) begin : g_wmask
        assign sram_wmask[8*i +: 8] = {8{req_wstrb[i] & req_we}};
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = mem_q[rd_ptr_q];
    assign idle      = !rd_pend_q && (count_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_pend_q <= fire & ~req_we;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= sram_rd;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == CNT_W'(RSP_DEPTH))));
    a_addr_in_range : assert property (@(posedge clk) disable iff (rst)
        !(sram_ce && (32'(req_addr) >= WORD_DEPTH)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_256x4096_1rw_ctrl.sv
// ============================================================================
//  Module   : tb_sram_256x4096_1rw_ctrl
//  Brief    : Scoreboard bench for sram_256x4096_1rw_ctrl with a macro model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_256x4096_1rw_ctrl;

    localparam int BITS       = 256;
    localparam int WORD_DEPTH = 4096;
    localparam int ADDR_WIDTH = 12;
    localparam int RSP_DEPTH  = 2;
    localparam int STRB_W     = BITS / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BITS-1:0]       req_wdata;
    logic [STRB_W-1:0]     req_wstrb;
    logic                  sram_ce;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [BITS-1:0]       sram_wd;
    logic [BITS-1:0]       sram_wmask;
    logic [BITS-1:0]       sram_rd;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [BITS-1:0]       rsp_rdata;
    logic                  idle;

    bit   [BITS-1:0] mac_mem [WORD_DEPTH];
    bit   [BITS-1:0] ref_mem [WORD_DEPTH];
    logic [BITS-1:0] exp_q [$];
    int checks   = 0;
    int failures = 0;
    int rsp_cnt  = 0;

    always #5 clk = ~clk;

    sram_256x4096_1rw_ctrl #(
        .BITS       (BITS),
        .WORD_DEPTH (WORD_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wd    (sram_wd),
        .sram_wmask (sram_wmask),
        .sram_rd    (sram_rd),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .idle       (idle)
    );

    // Behavioural macro: bit-masked write, read data appears the next cycle.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we)
                mac_mem[sram_addr] <= (mac_mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
            else
                sram_rd <= mac_mem[sram_addr];
        end
    end

    function automatic logic [BITS-1:0] strb2mask(input logic [STRB_W-1:0] s);
        logic [BITS-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_W; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic monitor_loop();
        logic [BITS-1:0] e;
        logic [BITS-1:0] m;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (rsp_valid && rsp_ready) begin
                    checks++;
                    rsp_cnt++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rsp_unexpected got=%h required=no response", rsp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (rsp_rdata !== e) begin
                            failures++;
                            $display("FAIL rsp_data got=%h required=%h", rsp_rdata, e);
                        end
                    end
                end
                if (req_valid && req_ready) begin
                    if (req_we) begin
                        m = strb2mask(req_wstrb);
                        ref_mem[req_addr] = (ref_mem[req_addr] & ~m) | (req_wdata & m);
                    end else begin
                        exp_q.push_back(ref_mem[req_addr]);
                    end
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(idle && exp_q.size() == 0) && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 64) begin
            failures++;
            $display("FAIL wait_idle_timeout got idle=%0b pending=%0d required idle=1 pending=0",
                     idle, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 4;
            if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b required=0", req_ready); end
            if (sram_ce !== 1'b0)   begin failures++; $display("FAIL rst_sram_ce got=%b required=0", sram_ce); end
            if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b required=0", rsp_valid); end
            if (idle !== 1'b1)      begin failures++; $display("FAIL rst_idle got=%b required=1", idle); end
            tick();
        end
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_req_ready got=%b required=1", req_ready); end
        tick();
    endtask

    task automatic test_write_read();
        logic [BITS-1:0] pat = {32{8'hA5}};
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h005; req_wdata = pat; req_wstrb = '1;
        @(negedge clk);
        checks += 3;
        if (sram_ce !== 1'b1 || sram_we !== 1'b1) begin failures++; $display("FAIL wr_strobes got ce=%b we=%b required ce=1 we=1", sram_ce, sram_we); end
        if (sram_wmask !== {BITS{1'b1}}) begin failures++; $display("FAIL wr_wmask got=%h required=all ones", sram_wmask); end
        if (sram_addr !== 12'h005 || sram_wd !== pat) begin failures++; $display("FAIL wr_addr_data got addr=%h wd=%h required addr=005 wd=%h", sram_addr, sram_wd, pat); end
        tick();
        req_we = 1'b0; req_wdata = '0;
        @(negedge clk);
        checks += 2;
        if (sram_ce !== 1'b1 || sram_we !== 1'b0) begin failures++; $display("FAIL rd_strobes got ce=%b we=%b required ce=1 we=0", sram_ce, sram_we); end
        if (sram_wmask !== '0) begin failures++; $display("FAIL rd_wmask got=%h required=0", sram_wmask); end
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_latency_early got rsp_valid=%b required=0", rsp_valid); end
        if (idle !== 1'b0)      begin failures++; $display("FAIL rd_inflight_idle got=%b required=0", idle); end
        tick();
        @(negedge clk);
        checks += 2;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rd_latency got rsp_valid=%b required=1", rsp_valid); end
        if (rsp_rdata !== pat)  begin failures++; $display("FAIL rd_data got=%h required=%h", rsp_rdata, pat); end
        tick();
        wait_idle();
    endtask

    task automatic test_byte_mask();
        logic [BITS-1:0] d;
        logic [BITS-1:0] em = '0;
        for (int w = 0; w < BITS/32; w++) d[32*w +: 32] = $urandom;
        em[7:0] = 8'hFF;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h010; req_wdata = d; req_wstrb = 32'h0000_0001;
        @(negedge clk);
        checks++;
        if (sram_wmask !== em) begin failures++; $display("FAIL byte_wmask got=%h required=%h", sram_wmask, em); end
        tick();
        req_we = 1'b0;
        tick();
        req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_pressure();
        logic [ADDR_WIDTH-1:0] addrs [4];
        logic [BITS-1:0] head_exp;
        int acc = 0;
        int n = 0;
        int base = rsp_cnt;
        logic last_ready = 1'b1;
        addrs[0] = 12'h005; addrs[1] = 12'h010; addrs[2] = 12'h020; addrs[3] = 12'h030;
        req_valid = 1'b1; req_we = 1'b1; req_wstrb = '1;
        req_addr = 12'h020; req_wdata = {8{32'h1234_5678}}; tick();
        req_addr = 12'h030; req_wdata = {8{32'h9ABC_DEF0}}; tick();
        head_exp = ref_mem[addrs[0]];
        rsp_ready = 1'b0;
        req_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_valid = (acc < 4);
            req_addr  = addrs[acc % 4];
            @(negedge clk);
            last_ready = req_ready;
            if (req_valid && req_ready) acc++;
            tick();
        end
        checks += 3;
        if (acc !== 2) begin failures++; $display("FAIL bp_accepted got=%0d required=2", acc); end
        if (last_ready !== 1'b0) begin failures++; $display("FAIL bp_read_ready got=%b required=0", last_ready); end
        if (rsp_valid !== 1'b1 || rsp_rdata !== head_exp) begin failures++; $display("FAIL bp_head_hold got v=%b d=%h required v=1 d=%h", rsp_valid, rsp_rdata, head_exp); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h040; req_wdata = {32{8'h3C}}; req_wstrb = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_write_ready got=%b required=1", req_ready); end
        tick();
        req_we = 1'b0;
        rsp_ready = 1'b1;
        while (acc < 4 && n < 32) begin
            req_valid = 1'b1;
            req_addr  = addrs[acc];
            @(negedge clk);
            if (req_ready) acc++;
            tick();
            n++;
        end
        req_valid = 1'b0;
        wait_idle();
        checks++;
        if (rsp_cnt - base !== 4) begin failures++; $display("FAIL bp_rsp_count got=%0d required=4", rsp_cnt - base); end
    endtask

    task automatic test_streaming();
        int stalls = 0;
        int nv = 0;
        bit seen = 1'b0;
        bit ended = 1'b0;
        bit gap = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_wstrb = '1;
        for (int a = 0; a < 16; a++) begin
            req_addr  = ADDR_WIDTH'(a);
            req_wdata = {8{32'hC0DE_0000 | 32'(a)}};
            tick();
        end
        req_we = 1'b0;
        for (int k = 0; k < 22; k++) begin
            req_valid = (k < 16);
            req_addr  = ADDR_WIDTH'(k % 16);
            @(negedge clk);
            if (req_valid && !req_ready) stalls++;
            if (rsp_valid) begin
                if (ended) gap = 1'b1;
                nv++;
                seen = 1'b1;
            end else if (seen) begin
                ended = 1'b1;
            end
            tick();
        end
        req_valid = 1'b0;
        checks += 3;
        if (stalls !== 0) begin failures++; $display("FAIL stream_stalls got=%0d required=0", stalls); end
        if (nv !== 16)    begin failures++; $display("FAIL stream_rsp_cycles got=%0d required=16", nv); end
        if (gap)          begin failures++; $display("FAIL stream_gap got=1 required=0"); end
        wait_idle();
    endtask

    task automatic test_reset_mid_read();
        int late = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h003;
        tick();
        req_valid = 1'b0;
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL mid_inflight_idle got=%b required=0", idle); end
        rst = 1'b1;
        #1;
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL mid_async_idle got=%b required=1", idle); end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) late++;
            tick();
        end
        checks += 2;
        if (late !== 0)    begin failures++; $display("FAIL mid_stale_rsp got=%0d cycles required=0", late); end
        if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b required=1", idle); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        fork
            monitor_loop();
        join_none
        #2;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_back_pressure();
        test_streaming();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
